// File: rtl/mul_appr_booth16.sv
// mul_appr_booth16 -- pipelined 16x16 signed approximate multiplier built on
// radix-4 (modified) Booth encoding of B.
//
// Each of the eight Booth partial products has its APPR_COLS least-significant
// bits cleared before the partial products are summed. In two's complement,
// clearing the low bits rounds each partial product toward minus infinity, so
// the result is never larger than the exact product:
//   out - A*B  lies in  [-8*(2^APPR_COLS - 1), 0]
// The low APPR_COLS bits of out are always zero.
//
// Build option:
//   MUL_APPR_EXACT_EN  when defined, the truncation logic is not built and the
//                      multiplier is exact. Latency and handshake do not change.
//
// Parameters:
//   APPR_COLS  number of truncated product columns, 0..16 (0 = exact)
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   rst_n      synchronous active-low reset; clears all pipeline state
//   in_valid   A/B carry an operand pair this cycle
//   A          signed multiplicand (two's complement)
//   B          signed multiplier (two's complement), Booth-encoded
//   out_valid  out carries a new result; asserted 2 cycles after in_valid
//   out        signed approximate product; holds its value while out_valid=0
module mul_appr_booth16 #(
  parameter int APPR_COLS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        out_valid,
  output logic [31:0] out
);

  // Stage 1: operand capture
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        v1_q;

  // Stage 2: result
  logic [31:0] out_q;
  logic [31:0] out_d;
  logic        out_valid_q;

  // Sign-extended multiplicand and multiplier with the implicit B[-1]=0
  // appended, so every Booth triplet is a plain 3-bit slice.
  logic [31:0] a_ext;
  logic [16:0] b_ext;

  assign a_ext = {{16{a_q[15]}}, a_q};
  assign b_ext = {b_q, 1'b0};

  logic [31:0] pp      [8];
  logic [31:0] pp_keep [8];

`ifndef MUL_APPR_EXACT_EN
  // Ones above the truncated columns; ANDing clears the low APPR_COLS bits.
  localparam logic [31:0] TRUNC_MASK = ~((32'd1 << APPR_COLS) - 32'd1);
`endif

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_booth_row
      logic [2:0]  trip;
      logic [31:0] mult;

      // Triplet (B[2i+1], B[2i], B[2i-1]) selects digit in {-2,-1,0,+1,+2}.
      assign trip = b_ext[2*gi+2 -: 3];

      always_comb begin
        mult = '0;
        case (trip)
          3'b001, 3'b010: mult = a_ext;
          3'b011:         mult = a_ext << 1;
          3'b100:         mult = -(a_ext << 1);
          3'b101, 3'b110: mult = -a_ext;
          default:        mult = '0;
        endcase
      end

      // Digit weight is 4^i.
      assign pp[gi] = mult << (2*gi);

`ifdef MUL_APPR_EXACT_EN
      assign pp_keep[gi] = pp[gi];
`else
      assign pp_keep[gi] = pp[gi] & TRUNC_MASK;
`endif
    end
  endgenerate

  // Exact modulo-2^32 sum of the (possibly truncated) partial products.
  always_comb begin
    out_d = '0;
    for (int i = 0; i < 8; i++) begin
      out_d = out_d + pp_keep[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      v1_q        <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      a_q         <= A;
      b_q         <= B;
      v1_q        <= in_valid;
      out_valid_q <= v1_q;
      if (v1_q) begin
        out_q <= out_d;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mul_appr_booth16.sv
module tb_mul_appr_booth16;

  localparam int APPR = 8;
`ifdef MUL_APPR_EXACT_EN
  localparam int K_EFF = 0;
`else
  localparam int K_EFF = APPR;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        out_valid;
  logic [31:0] out;

  int n_cmp = 0;
  int n_fail = 0;

  mul_appr_booth16 #(.APPR_COLS(APPR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out       (out)
  );

  always #5 clk = ~clk;

  // Reference: Booth digits from the recoding rule, each partial product
  // rounded down to a multiple of 2^k by floor division, then summed.
  function automatic longint ref_mul(input logic [15:0] a, input logic [15:0] b, input int k);
    longint sa, acc, pp, m, r;
    int d, bm1;
    sa  = longint'($signed(a));
    acc = 0;
    m   = longint'(1) << k;
    for (int i = 0; i < 8; i++) begin
      bm1 = (i == 0) ? 0 : int'(b[2*i-1]);
      d   = -2 * int'(b[2*i+1]) + int'(b[2*i]) + bm1;
      pp  = longint'(d) * sa * (longint'(1) << (2*i));
      r   = pp % m;
      if (r < 0) r = r + m;
      acc = acc + (pp - r);
    end
    return acc;
  endfunction

  // Model of the 2-deep pipeline: expected output state for the current cycle.
  logic        vpipe [2];
  logic [31:0] epipe [2];
  longint      xpipe [2];
  logic        exp_valid;
  logic [31:0] exp_out;
  longint      exp_exact;
  logic [31:0] model_last;

  task automatic model_clear();
    vpipe[0] = 1'b0; vpipe[1] = 1'b0;
    epipe[0] = '0;   epipe[1] = '0;
    xpipe[0] = 0;    xpipe[1] = 0;
    model_last = '0;
  endtask

  // Advance one clock, update the expected DUT state, then drive new inputs.
  task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b);
    longint r;
    @(posedge clk);
    #1;
    exp_valid = vpipe[1];
    if (vpipe[1]) model_last = epipe[1];
    exp_out   = model_last;
    exp_exact = xpipe[1];
    vpipe[1] = vpipe[0]; epipe[1] = epipe[0]; xpipe[1] = xpipe[0];
    r = ref_mul(a, b, K_EFF);
    vpipe[0] = v;
    epipe[0] = r[31:0];
    xpipe[0] = longint'($signed(a)) * longint'($signed(b));
    in_valid = v;
    A = a;
    B = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    A = 16'd1234;
    B = 16'd5678;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || out !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d: out_valid=%b out=%0d, required out_valid=0 out=0", i, out_valid, out);
      end
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    model_clear();
    step(1'b0, 16'd0, 16'd0);
    step(1'b1, 16'd300, 16'hFFF6);
    step(1'b0, 16'd0, 16'd0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_latency1: out_valid=%b, required 0", out_valid);
    end
    step(1'b0, 16'd0, 16'd0);
    n_cmp++;
    if (out_valid !== 1'b1 || out !== exp_out) begin
      n_fail++;
      $display("FAIL reset_latency2: out_valid=%b out=%0d, required out_valid=1 out=%0d", out_valid, $signed(out), $signed(exp_out));
    end
    $display("reset: first result out=%0d", $signed(out));
  endtask

  task automatic test_directed();
    logic [15:0] ta [5];
    logic [15:0] tb [5];
    logic [31:0] te [5];
    int n;
`ifdef MUL_APPR_EXACT_EN
    n = 3;
    ta[0] = 16'd1000;  tb[0] = 16'd1000;  te[0] = 32'd1000000;
    ta[1] = 16'd3;     tb[1] = 16'd3;     te[1] = 32'd9;
    ta[2] = 16'h8000;  tb[2] = 16'h8000;  te[2] = 32'd1073741824;
`else
    n = 5;
    ta[0] = 16'd1000;  tb[0] = 16'd1000;  te[0] = 32'd999680;
    ta[1] = 16'hFFFF;  tb[1] = 16'd1;     te[1] = 32'hFFFFFF00;
    ta[2] = 16'd0;     tb[2] = 16'hCFC7;  te[2] = 32'd0;
    ta[3] = 16'h8000;  tb[3] = 16'h8000;  te[3] = 32'd1073741824;
    ta[4] = 16'd32767; tb[4] = 16'h8000;  te[4] = 32'hC0008000;
`endif
    for (int i = 0; i < n; i++) begin
      step(1'b1, ta[i], tb[i]);
      step(1'b0, 16'd0, 16'd0);
      step(1'b0, 16'd0, 16'd0);
      n_cmp++;
      if (out_valid !== 1'b1 || out !== te[i]) begin
        n_fail++;
        $display("FAIL directed[%0d] A=%0d B=%0d: out_valid=%b out=%0d, required 1 / %0d",
                 i, $signed(ta[i]), $signed(tb[i]), out_valid, $signed(out), $signed(te[i]));
      end else begin
        $display("directed[%0d] A=%0d B=%0d out=%0d", i, $signed(ta[i]), $signed(tb[i]), $signed(out));
      end
      // Result must hold once out_valid drops.
      step(1'b0, 16'd0, 16'd0);
      n_cmp++;
      if (out_valid !== 1'b0 || out !== te[i]) begin
        n_fail++;
        $display("FAIL hold[%0d]: out_valid=%b out=%0d, required 0 / %0d", i, out_valid, $signed(out), $signed(te[i]));
      end
    end
  endtask

  task automatic test_back_to_back();
    int issued = 0;
    int cyc = 0;
    logic v;
    logic [15:0] a, b;
    longint err, lo;
    lo = -8 * ((longint'(1) << K_EFF) - 1);
    while (issued < 100 || cyc < 2) begin
      if (issued < 100) begin
        v = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 7))
          0: a = 16'h8000;
          1: a = 16'h7FFF;
          default: a = 16'($urandom);
        endcase
        case ($urandom_range(0, 7))
          0: b = 16'h8000;
          1: b = 16'hFFFF;
          default: b = 16'($urandom);
        endcase
        if (v) issued++;
      end else begin
        v = 1'b0; a = '0; b = '0;
        cyc++;
      end
      step(v, a, b);
      n_cmp++;
      if (out_valid !== exp_valid || out !== exp_out) begin
        n_fail++;
        $display("FAIL b2b: out_valid=%b out=%0d, required %b / %0d", out_valid, $signed(out), exp_valid, $signed(exp_out));
      end else if (exp_valid) begin
        $display("b2b: out=%0d exact=%0d", $signed(out), exp_exact);
      end
      if (exp_valid) begin
        err = longint'($signed(out)) - exp_exact;
        n_cmp++;
        if (err > 0 || err < lo) begin
          n_fail++;
          $display("FAIL err_bound: error=%0d, required within [%0d, 0]", err, lo);
        end
      end
    end
  endtask

  task automatic test_midreset();
    step(1'b1, 16'd77, 16'd99);
    step(1'b1, 16'd55, 16'd33);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'd0, 16'd0);
      n_cmp++;
      if (out_valid !== 1'b0 || out !== 32'd0) begin
        n_fail++;
        $display("FAIL midreset cyc=%0d: out_valid=%b out=%0d, required 0 / 0", i, out_valid, $signed(out));
      end
    end
    $display("midreset: in-flight operands discarded");
  endtask

  initial begin
    model_clear();
    exp_valid = 1'b0;
    exp_out = '0;
    exp_exact = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_appr_booth16.md
Name: mul_appr_booth16

Overview:
- Pipelined 16x16 signed approximate multiplier using radix-4 (modified) Booth encoding.
- Low-order partial-product columns are truncated to save adder area, trading a bounded, always non-positive error for fewer compressor cells.
- Sits in DSP datapaths (fixed-point coefficient multiply); downstream logic typically right-shifts the 32-bit product, which hides most of the truncation error.

Parameters:
- APPR_COLS, 8, number of least-significant product columns (0..16) whose partial-product bits are discarded; 0 = exact multiplier.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  A/B valid this cycle
- A  input  16  signed multiplicand (two's complement)
- B  input  16  signed multiplier (two's complement), Booth-encoded operand
- out_valid  output  1  out holds a result
- out  output  32  signed approximate product A*B (two's complement)

Behaviour:
- Interface: one clock (clk); reset synchronous, active-low (rst_n).
- Reset (rst_n=0 at clk edge): out=0, out_valid=0, stage-1 registers and valid cleared. Reset mid-operation discards all in-flight operands.
- Pipeline, latency 2, throughput 1/cycle, no backpressure:
  - Stage 1 registers A, B and in_valid.
  - Stage 2 computes the product combinationally and registers out and out_valid.
  - out_valid(n+2) = in_valid(n).
  - out holds its last value while out_valid=0.
- Booth encoding:
  - For i=0..7, digit d_i is taken from triplet (B[2i+1], B[2i], B[2i-1]), with B[-1]=0.
  - Mapping: 000/111 -> 0; 001/010 -> +1; 011 -> +2; 100 -> -2; 101/110 -> -1.
  - Identity: sum of d_i*4^i = B for all 16-bit signed B, including -32768.
- Partial products: PP_i = d_i * A * 4^i, formed exactly as a signed 32-bit value. Negation is exact two's complement.
- Approximation:
  - Each PP_i has bits [APPR_COLS-1:0] forced to 0, i.e. PP_i' = floor(PP_i / 2^APPR_COLS) * 2^APPR_COLS.
  - out = sum of PP_i' mod 2^32, computed with an exact adder tree or compressor tree.
  - The low APPR_COLS bits of out are therefore always 0.
- Error bound: out - A*B lies in [-8*(2^APPR_COLS - 1), 0]. A zero digit or aligned PP contributes no error.
- Width: the exact product fits in 32 bits for all inputs, including (-32768)^2 = 2^30. No overflow handling is required.

Optional Feature:
- Macro MUL_APPR_EXACT_EN.
- Defined: truncation logic is compiled out and the effective APPR_COLS is 0, so out = A*B exactly for all inputs. Latency and handshake are unchanged.
- Undefined: truncation per APPR_COLS as specified above.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out=0, out_valid=0. Release; first out_valid appears exactly 2 cycles after the first sampled in_valid.
- APPR_COLS=8: A=1000, B=1000 -> digits d1=-2, d2=-1, d5=+1; PPs -8000/-16000/1024000 truncate to -8192/-16128/1024000 -> out=999680 (error -320).
- APPR_COLS=8: A=-1, B=1 -> out=-256; A=0, B=-12345 -> out=0.
- APPR_COLS=8: A=-32768, B=-32768 -> out=1073741824 (exact). A=32767, B=-32768 -> out=-1073709056 (exact, since PP aligned).
- Throughput: 100 back-to-back random pairs with in_valid toggling -> each out matches the reference model (Booth truncation formula) 2 cycles later, and error stays within [-2040, 0].
- MUL_APPR_EXACT_EN defined: A=1000, B=1000 -> out=1000000; A=3, B=3 -> out=9; random sweep shows zero error.
